control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that drives the 32-bit bus datapath's enable and select strobes.
- It fetches each instruction over three cycles, then walks a per-class micro-step sequence that asserts the register in/out one-hots, special-register strobes and ALU opcode.
- It sits beside the datapath and consumes only the IR register output (plus an optional memory-ready input).

Parameters:
- RESET_PC_WAIT, 0, number of idle cycles after reset release before the first fetch (0–3).

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  asynchronous active-low reset
- ir  in  32  IR register output; fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
- stop  in  1  request halt at the next instruction boundary
- mem_ready  in  1  memory ready (present only with MEM_WAIT_EN)
- reg_in  out  16  one-hot R0in..R15in
- reg_out  out  16  one-hot R0out..R15out
- PCout, PCin, IncPC, MARin, MDRin, MDRread, mem_write, IRin  out  1 each
- Yin, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout  out  1 each
- ALU_opcode  out  5  ALU operation during Zin cycles, else 0
- run  out  1  high while executing
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
Reset
- clr low: state=IDLE; all outputs 0, including run.
- Reset asserted mid-instruction aborts it immediately, with no partial strobes.
- After release: RESET_PC_WAIT idle cycles, then T0 with run=1.

Outputs
- Moore decode of the state register plus the ir fields. ir is stable from T3 until instruction end, because IRin fires only in T2.

Fetch (every instruction)
- T0: PCout, MARin, IncPC.
- T1: MDRread, MDRin.
- T2: MDRout, IRin.
- MDRout is not a port; the datapath bus treats MDRout as MDRin-delayed. Decided: T2 drives IRin only, and the bus select is the datapath's concern.

Opcodes and ALU_opcode mapping
- ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 01001, shl 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, jr 10101, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- ALU_opcode equals the opcode for R-type, mul and div.
- addi, ld, st use 00011; andi uses 00101; ori uses 00110.

Execute sequences
- R-type: T3 reg_out[Rb], Yin; T4 reg_out[Rc], ALU_opcode, Zin; T5 ZLowSelect, ZLOout, reg_in[Ra].
- Immediate: T3 reg_out[Rb], Yin; T4 Cout, ALU_opcode, Zin; T5 ZLowSelect, ZLOout, reg_in[Ra].
- mul/div: T3 reg_out[Ra], Yin; T4 reg_out[Rb], Zin; T5 ZLowSelect, ZLOout, Loin; T6 ZHighSelect, ZHIout, HIin.
- ld: T3–T4 as immediate; T5 ZLowSelect, ZLOout, MARin; T6 MDRread, MDRin; T7 reg_in[Ra].
- st: T3–T5 as ld; T6 reg_out[Ra], MDRin (MDRread=0); T7 mem_write.
- jr: T3 reg_out[Ra], PCin.
- mfhi/mflo: T3 HIout/Loout, reg_in[Ra].
- nop: returns to T0 after T2.
- halt: enters HALTED; run=0, all strobes 0.
- Undefined opcode: illegal_op pulses in T3, then proceeds to T0 (executes as nop).

Boundaries
- stop sampled at the last step of each instruction: if high, go to HALTED instead of T0. stop never truncates an instruction.
- HALTED is left only by reset.
- At most one reg_out bit set in any cycle. reg_in and reg_out are never both nonzero in the same cycle.
- Ra=Rb is legal; no special handling.

Optional Feature:
CTRL_MEM_WAIT_EN
- Defined: mem_ready port exists. T1, ld-T6 and st-T7 hold their strobes and do not advance until mem_ready=1 is sampled. Reset overrides the wait.
- Undefined: no port; memory steps last exactly one cycle.

Decomposition:
- Package cpu_ctrl_pkg: opcode localparams, ALU opcode constants, state enumeration (IDLE, T0–T7, HALTED), IR field bit positions.
- Sub-module reg_select_decoder: 4-to-16 one-hot with enable, instantiated twice (reg_in, reg_out).
- Sequencer FSM and strobe decode stay in control_sequencer.

Test Plan:
- Reset: clr=0 mid-T4 of add → all outputs 0 and run=0 immediately. Release with RESET_PC_WAIT=0 → T0 on the next edge: PCout=MARin=IncPC=1.
- add R3,R1,R2 (ir=0x19890000) → T3 reg_out=0x0002, Yin; T4 reg_out=0x0004, ALU_opcode=00011, Zin; T5 reg_in=0x0008, ZLOout; next cycle T0. Instruction total 6 cycles.
- ld R2 with Rb=R4 (ir=0x01200010) → T5 MARin with ZLOout; T6 MDRread=MDRin=1; T7 reg_in=0x0004; 8 cycles total.
- mul R5,R6 (ir=0x7AB00000) → T5 Loin, T6 HIin; ZLowSelect and ZHighSelect each high exactly one cycle.
- stop raised during T4 of sub → T5 completes, then HALTED with run=0. Likewise halt opcode → HALTED after T2, no further PCout.
- Opcode 11111 → illegal_op one pulse in T3, then T0. With CTRL_MEM_WAIT_EN and mem_ready=0 for 3 cycles in T1 → MDRread held 4 cycles, then T2.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: IR field positions, opcodes,
// ALU operation codes, sequencer states and instruction classes.
package cpu_ctrl_pkg;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b00101;
  localparam logic [4:0] ALU_OR   = 5'b00110;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_LD, CLS_ST, CLS_JR,
    CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } iclass_t;

  function automatic iclass_t decode_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:                      return CLS_IMM;
      OP_MUL, OP_DIV:                                return CLS_MULDIV;
      OP_LD:                                         return CLS_LD;
      OP_ST:                                         return CLS_ST;
      OP_JR:                                         return CLS_JR;
      OP_MFHI:                                       return CLS_MFHI;
      OP_MFLO:                                       return CLS_MFLO;
      OP_NOP:                                        return CLS_NOP;
      OP_HALT:                                       return CLS_HALT;
      default:                                       return CLS_ILLEGAL;
    endcase
  endfunction

  // Immediates and address arithmetic reuse the register-form ALU codes.
  function automatic logic [4:0] alu_op_for(input iclass_t cls, input logic [4:0] op);
    case (cls)
      CLS_RTYPE, CLS_MULDIV: return op;
      CLS_IMM: begin
        case (op)
          OP_ANDI: return ALU_AND;
          OP_ORI:  return ALU_OR;
          default: return ALU_ADD;
        endcase
      end
      CLS_LD, CLS_ST:        return ALU_ADD;
      default:               return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; purely combinational, no stall.
module reg_select_decoder (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: 3-cycle fetch then per-class micro-steps, Moore strobes.
// Optional CTRL_MEM_WAIT_EN adds mem_ready; memory steps then stall until it is sampled high.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_WAIT = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
`ifdef CTRL_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRread,
  output logic        mem_write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowSelect,
  output logic        ZHighSelect,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIin,
  output logic        Loin,
  output logic        HIout,
  output logic        Loout,
  output logic        Cout,
  output logic [4:0]  ALU_opcode,
  output logic        run,
  output logic        illegal_op
);

  localparam logic [1:0] WAIT_CYC = 2'(RESET_PC_WAIT);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_wait;
  logic        w_wait_done;
  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  iclass_t     w_cls;
  logic        w_mem_ok;
  logic        w_last;
  logic        w_in_en;
  logic        w_out_en;
  logic [3:0]  w_in_sel;
  logic [3:0]  w_out_sel;
  logic        w_unused_ir;

  assign w_op        = ir[IR_OP_MSB:IR_OP_LSB];
  assign w_ra        = ir[IR_RA_MSB:IR_RA_LSB];
  assign w_rb        = ir[IR_RB_MSB:IR_RB_LSB];
  assign w_rc        = ir[IR_RC_MSB:IR_RC_LSB];
  assign w_cls       = decode_class(w_op);
  assign w_wait_done = (r_wait == WAIT_CYC);
  assign w_unused_ir = ^ir[IR_RC_LSB-1:0];

`ifdef CTRL_MEM_WAIT_EN
  assign w_mem_ok = mem_ready;
`else
  assign w_mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                                r_wait <= 2'd0;
    else if (r_state == IDLE && !w_wait_done) r_wait <= r_wait + 2'd1;
  end

  always_comb begin
    w_next      = r_state;
    w_last      = 1'b0;
    w_in_en     = 1'b0;
    w_out_en    = 1'b0;
    w_in_sel    = w_ra;
    w_out_sel   = w_ra;
    PCout       = 1'b0;
    PCin        = 1'b0;
    IncPC       = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRread     = 1'b0;
    mem_write   = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    ZLowSelect  = 1'b0;
    ZHighSelect = 1'b0;
    ZLOout      = 1'b0;
    ZHIout      = 1'b0;
    HIin        = 1'b0;
    Loin        = 1'b0;
    HIout       = 1'b0;
    Loout       = 1'b0;
    Cout        = 1'b0;
    ALU_opcode  = ALU_NONE;
    illegal_op  = 1'b0;
    run         = (r_state != IDLE) && (r_state != HALTED);

    case (r_state)
      IDLE: if (w_wait_done) w_next = T0;
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        w_next = T1;
      end
      T1: begin
        MDRread = 1'b1;
        MDRin   = 1'b1;
        if (w_mem_ok) w_next = T2;
      end
      // nop and halt finish here, so their exit is chosen from the opcode in T2.
      T2: begin
        IRin = 1'b1;
        case (w_cls)
          CLS_HALT: w_next = HALTED;
          CLS_NOP:  w_last = 1'b1;
          default:  w_next = T3;
        endcase
      end
      T3: begin
        case (w_cls)
          CLS_RTYPE, CLS_IMM, CLS_LD, CLS_ST: begin
            w_out_en  = 1'b1;
            w_out_sel = w_rb;
            Yin       = 1'b1;
            w_next    = T4;
          end
          CLS_MULDIV: begin
            w_out_en = 1'b1;
            Yin      = 1'b1;
            w_next   = T4;
          end
          CLS_JR: begin
            w_out_en = 1'b1;
            PCin     = 1'b1;
            w_last   = 1'b1;
          end
          CLS_MFHI: begin
            HIout   = 1'b1;
            w_in_en = 1'b1;
            w_last  = 1'b1;
          end
          CLS_MFLO: begin
            Loout   = 1'b1;
            w_in_en = 1'b1;
            w_last  = 1'b1;
          end
          CLS_ILLEGAL: begin
            illegal_op = 1'b1;
            w_last     = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      T4: begin
        case (w_cls)
          CLS_RTYPE, CLS_MULDIV, CLS_IMM, CLS_LD, CLS_ST: begin
            Zin        = 1'b1;
            ALU_opcode = alu_op_for(w_cls, w_op);
            w_next     = T5;
            if (w_cls == CLS_RTYPE) begin
              w_out_en  = 1'b1;
              w_out_sel = w_rc;
            end else if (w_cls == CLS_MULDIV) begin
              w_out_en  = 1'b1;
              w_out_sel = w_rb;
            end else begin
              Cout = 1'b1;
            end
          end
          default: w_last = 1'b1;
        endcase
      end
      T5: begin
        case (w_cls)
          CLS_RTYPE, CLS_IMM: begin
            ZLowSelect = 1'b1;
            ZLOout     = 1'b1;
            w_in_en    = 1'b1;
            w_last     = 1'b1;
          end
          CLS_MULDIV: begin
            ZLowSelect = 1'b1;
            ZLOout     = 1'b1;
            Loin       = 1'b1;
            w_next     = T6;
          end
          CLS_LD, CLS_ST: begin
            ZLowSelect = 1'b1;
            ZLOout     = 1'b1;
            MARin      = 1'b1;
            w_next     = T6;
          end
          default: w_last = 1'b1;
        endcase
      end
      T6: begin
        case (w_cls)
          CLS_MULDIV: begin
            ZHighSelect = 1'b1;
            ZHIout      = 1'b1;
            HIin        = 1'b1;
            w_last      = 1'b1;
          end
          CLS_LD: begin
            MDRread = 1'b1;
            MDRin   = 1'b1;
            if (w_mem_ok) w_next = T7;
          end
          CLS_ST: begin
            w_out_en = 1'b1;
            MDRin    = 1'b1;
            w_next   = T7;
          end
          default: w_last = 1'b1;
        endcase
      end
      T7: begin
        case (w_cls)
          CLS_LD: begin
            w_in_en = 1'b1;
            w_last  = 1'b1;
          end
          CLS_ST: begin
            mem_write = 1'b1;
            if (w_mem_ok) w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      HALTED: w_next = HALTED;
      default: w_next = IDLE;
    endcase

    // stop is only honoured on the final step so an instruction is never cut short.
    if (w_last) w_next = stop ? HALTED : T0;
  end

  reg_select_decoder u_in_dec (
    .i_en     (w_in_en),
    .i_sel    (w_in_sel),
    .o_onehot (reg_in)
  );

  reg_select_decoder u_out_dec (
    .i_en     (w_out_en),
    .i_sel    (w_out_sel),
    .o_onehot (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expected control words, negedge monitor compares.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        stop;
`ifdef CTRL_MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic [15:0] reg_in, reg_out;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRread, mem_write, IRin;
  logic Yin, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin, HIout, Loout, Cout;
  logic [4:0] ALU_opcode;
  logic run, illegal_op;

  always #5 clk = ~clk;

  control_sequencer #(.RESET_PC_WAIT(0)) dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .reg_in(reg_in), .reg_out(reg_out),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRread(MDRread), .mem_write(mem_write), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .Loin(Loin),
    .HIout(HIout), .Loout(Loout), .Cout(Cout),
    .ALU_opcode(ALU_opcode), .run(run), .illegal_op(illegal_op)
  );

  localparam logic [18:0] S_PCOUT = 19'h40000, S_PCIN  = 19'h20000, S_INCPC = 19'h10000;
  localparam logic [18:0] S_MARIN = 19'h08000, S_MDRIN = 19'h04000, S_MDRRD = 19'h02000;
  localparam logic [18:0] S_MEMW  = 19'h01000, S_IRIN  = 19'h00800, S_YIN   = 19'h00400;
  localparam logic [18:0] S_ZIN   = 19'h00200, S_ZLSEL = 19'h00100, S_ZHSEL = 19'h00080;
  localparam logic [18:0] S_ZLO   = 19'h00040, S_ZHI   = 19'h00020, S_HIIN  = 19'h00010;
  localparam logic [18:0] S_LOIN  = 19'h00008, S_HIOUT = 19'h00004, S_LOOUT = 19'h00002;
  localparam logic [18:0] S_COUT  = 19'h00001;
  localparam logic [57:0] W_ZERO  = '0;

  logic [57:0] act_w;
  assign act_w = {reg_in, reg_out, PCout, PCin, IncPC, MARin, MDRin, MDRread, mem_write, IRin,
                  Yin, Zin, ZLowSelect, ZHighSelect, ZLOout, ZHIout, HIin, Loin, HIout, Loout,
                  Cout, ALU_opcode, run, illegal_op};

  typedef struct {
    logic [57:0] w;
    int          step;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    checks = 0;
  int    errors = 0;
  int    step_n = 0;
  string cur_name = "reset";

  function automatic logic [57:0] cw(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [18:0] s, input logic [4:0] alu,
                                     input logic ill);
    return {rin, rout, s, alu, 1'b1, ill};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (act_w !== mon_e.w) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", cur_name, mon_e.step, act_w, mon_e.w);
      end
    end
  end

  task automatic push(input logic [57:0] w);
    exp_t e;
    e.w = w;
    e.step = step_n;
    step_n++;
    exp_q.push_back(e);
  endtask

  task automatic fetch();
    push(cw(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_MDRRD | S_MDRIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_IRIN, 5'd0, 1'b0));
  endtask

  task automatic start(input string nm, input logic [31:0] v);
    @(posedge clk);
    #1;
    cur_name = nm;
    step_n = 0;
    ir = v;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 100) begin
        $display("FAIL %s: expected cycles never consumed", cur_name);
        $fatal(1, "scoreboard stalled");
      end
    end
  endtask

  // act 1 raises stop, act 2 raises mem_ready, once word act_step has been checked.
  task automatic finish_instr(input int act_step, input int act);
    int n = exp_q.size();
    if (act != 0) begin
      while (exp_q.size() > n - (act_step + 1)) begin
        @(negedge clk);
        #1;
      end
      if (act == 1) stop = 1'b1;
`ifdef CTRL_MEM_WAIT_EN
      else mem_ready = 1'b1;
`endif
    end
    drain();
  endtask

  initial begin
    clr = 1'b1;
    ir = 32'h0;
    stop = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    #2 clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(W_ZERO);
    drain();
    clr = 1'b1;

    start("add_abort", 32'h19890000);
    fetch();
    push(cw(16'h0, 16'h0002, S_YIN, 5'd0, 1'b0));
    finish_instr(0, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    cur_name = "reset_mid_T4";
    step_n = 0;
    push(W_ZERO);
    drain();
    clr = 1'b1;

    start("add", 32'h19890000);
    fetch();
    push(cw(16'h0, 16'h0002, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0004, S_ZIN, 5'b00011, 1'b0));
    push(cw(16'h0008, 16'h0, S_ZLSEL | S_ZLO, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("ld", 32'h01200010);
    fetch();
    push(cw(16'h0, 16'h0010, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_COUT | S_ZIN, 5'b00011, 1'b0));
    push(cw(16'h0, 16'h0, S_ZLSEL | S_ZLO | S_MARIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_MDRRD | S_MDRIN, 5'd0, 1'b0));
    push(cw(16'h0004, 16'h0, 19'h0, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("st", 32'h13880000);
    fetch();
    push(cw(16'h0, 16'h0002, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_COUT | S_ZIN, 5'b00011, 1'b0));
    push(cw(16'h0, 16'h0, S_ZLSEL | S_ZLO | S_MARIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0080, S_MDRIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_MEMW, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("mul", 32'h7AB00000);
    fetch();
    push(cw(16'h0, 16'h0020, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0040, S_ZIN, 5'b01111, 1'b0));
    push(cw(16'h0, 16'h0, S_ZLSEL | S_ZLO | S_LOIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_ZHSEL | S_ZHI | S_HIIN, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("div", 32'h81180000);
    fetch();
    push(cw(16'h0, 16'h0004, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0008, S_ZIN, 5'b10000, 1'b0));
    push(cw(16'h0, 16'h0, S_ZLSEL | S_ZLO | S_LOIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_ZHSEL | S_ZHI | S_HIIN, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("addi", 32'h60900000);
    fetch();
    push(cw(16'h0, 16'h0004, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_COUT | S_ZIN, 5'b00011, 1'b0));
    push(cw(16'h0002, 16'h0, S_ZLSEL | S_ZLO, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("ori", 32'h70000000);
    fetch();
    push(cw(16'h0, 16'h0001, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_COUT | S_ZIN, 5'b00110, 1'b0));
    push(cw(16'h0001, 16'h0, S_ZLSEL | S_ZLO, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("shr", 32'h4A2B0000);
    fetch();
    push(cw(16'h0, 16'h0020, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0040, S_ZIN, 5'b01001, 1'b0));
    push(cw(16'h0010, 16'h0, S_ZLSEL | S_ZLO, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("jr", 32'hAC800000);
    fetch();
    push(cw(16'h0, 16'h0200, S_PCIN, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("mfhi", 32'hC5000000);
    fetch();
    push(cw(16'h0400, 16'h0, S_HIOUT, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("mflo", 32'hCF800000);
    fetch();
    push(cw(16'h8000, 16'h0, S_LOOUT, 5'd0, 1'b0));
    finish_instr(0, 0);

    start("nop", 32'hD0000000);
    fetch();
    finish_instr(0, 0);

    start("illegal", 32'hF8000000);
    fetch();
    push(cw(16'h0, 16'h0, 19'h0, 5'd0, 1'b1));
    finish_instr(0, 0);

`ifdef CTRL_MEM_WAIT_EN
    start("mem_wait", 32'hD0000000);
    mem_ready = 1'b0;
    push(cw(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC, 5'd0, 1'b0));
    repeat (4) push(cw(16'h0, 16'h0, S_MDRRD | S_MDRIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0, S_IRIN, 5'd0, 1'b0));
    finish_instr(4, 2);
`endif

    start("sub_stop", 32'h20918000);
    fetch();
    push(cw(16'h0, 16'h0004, S_YIN, 5'd0, 1'b0));
    push(cw(16'h0, 16'h0008, S_ZIN, 5'b00100, 1'b0));
    push(cw(16'h0002, 16'h0, S_ZLSEL | S_ZLO, 5'd0, 1'b0));
    repeat (3) push(W_ZERO);
    finish_instr(4, 1);
    stop = 1'b0;

    clr = 1'b0;
    cur_name = "reset_from_halted";
    step_n = 0;
    push(W_ZERO);
    drain();
    clr = 1'b1;

    start("halt", 32'hD8000000);
    fetch();
    repeat (3) push(W_ZERO);
    finish_instr(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
